// File: rtl/picodevice_pkg.sv
// Shared definitions for the picodevice AXI4-lite arbiter.
//   - state_e   : arbiter FSM states
//   - MST_MEM / MST_DMM : master index constants (grant / priority encoding)
//   - ADDR_W, DATA_W, STRB_W, PROT_W : AXI4-lite field widths
package picodevice_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int PROT_W = 3;

  localparam logic MST_MEM = 1'b0;
  localparam logic MST_DMM = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/picodevice_arb_rr2.sv
// Two-input grant / priority-pointer logic for the picodevice AXI arbiter.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   req_i[1:0]   - request pair, bit MST_MEM = mem, bit MST_DMM = dmm
//   arb_en_i     - arbitration window (arbiter is idle)
//   done_i       - completion strobe of the granted transaction
//   win_o        - combinational winner for the current request pair
//   grant_o      - registered grant, loaded when arbitrating with a request
// Parameters:
//   ROUND_ROBIN     - 1: pointer moves to the master not just served; 0: mem fixed
//   DMM_FIRST_RESET - round-robin only: 1 gives dmm priority after reset
module picodevice_arb_rr2
  import picodevice_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN     = 1,
  parameter int unsigned DMM_FIRST_RESET = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req_i,
  input  logic       arb_en_i,
  input  logic       done_i,
  output logic       win_o,
  output logic       grant_o
);

  localparam logic PRIO_RST = ((ROUND_ROBIN != 0) && (DMM_FIRST_RESET != 0)) ? MST_DMM : MST_MEM;

  logic prio_q;
  logic grant_q;

  // Priority master wins if it requests; otherwise the other one (only
  // meaningful when at least one request is present).
  assign win_o   = req_i[prio_q] ? prio_q : ~prio_q;
  assign grant_o = grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q <= MST_MEM;
      prio_q  <= PRIO_RST;
    end else begin
      if (arb_en_i && (|req_i)) begin
        grant_q <= win_o;
      end
      if (done_i) begin
        prio_q <= (ROUND_ROBIN != 0) ? ~grant_q : MST_MEM;
      end
    end
  end

endmodule

// File: rtl/picodevice_axi_arbiter.sv
// 2:1 AXI4-lite arbiter merging the core memory master (mem_axi_*) and the
// data-mover master (dmm_axi_*) onto one master port (out_axi_*). A single
// transaction is outstanding; address, data and response all run under one
// grant. Outputs are fully gated by state, so in IDLE (and in reset) every
// valid, ready, address and data output is 0.
// Ports:
//   clk, resetn   - clock, asynchronous active-low reset
//   mem_axi_*     - slave side toward the core memory master
//   dmm_axi_*     - slave side toward the data-mover master
//   out_axi_*     - merged master side toward the interconnect
//   stat_mem_grants / stat_dmm_grants - completed-transaction counters,
//                   present only when PICODEVICE_AXI_ARBITER_STATS_EN is defined
// Parameters: ROUND_ROBIN, DMM_FIRST_RESET (see picodevice_arb_rr2).
module picodevice_axi_arbiter
  import picodevice_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN     = 1,
  parameter int unsigned DMM_FIRST_RESET = 0
) (
  input  logic              clk,
  input  logic              resetn,
  // mem master
  input  logic              mem_axi_awvalid,
  output logic              mem_axi_awready,
  input  logic [ADDR_W-1:0] mem_axi_awaddr,
  input  logic [PROT_W-1:0] mem_axi_awprot,
  input  logic              mem_axi_wvalid,
  output logic              mem_axi_wready,
  input  logic [DATA_W-1:0] mem_axi_wdata,
  input  logic [STRB_W-1:0] mem_axi_wstrb,
  output logic              mem_axi_bvalid,
  input  logic              mem_axi_bready,
  input  logic              mem_axi_arvalid,
  output logic              mem_axi_arready,
  input  logic [ADDR_W-1:0] mem_axi_araddr,
  input  logic [PROT_W-1:0] mem_axi_arprot,
  output logic              mem_axi_rvalid,
  input  logic              mem_axi_rready,
  output logic [DATA_W-1:0] mem_axi_rdata,
  // dmm master
  input  logic              dmm_axi_awvalid,
  output logic              dmm_axi_awready,
  input  logic [ADDR_W-1:0] dmm_axi_awaddr,
  input  logic [PROT_W-1:0] dmm_axi_awprot,
  input  logic              dmm_axi_wvalid,
  output logic              dmm_axi_wready,
  input  logic [DATA_W-1:0] dmm_axi_wdata,
  input  logic [STRB_W-1:0] dmm_axi_wstrb,
  output logic              dmm_axi_bvalid,
  input  logic              dmm_axi_bready,
  input  logic              dmm_axi_arvalid,
  output logic              dmm_axi_arready,
  input  logic [ADDR_W-1:0] dmm_axi_araddr,
  input  logic [PROT_W-1:0] dmm_axi_arprot,
  output logic              dmm_axi_rvalid,
  input  logic              dmm_axi_rready,
  output logic [DATA_W-1:0] dmm_axi_rdata,
  // merged master
  output logic              out_axi_awvalid,
  input  logic              out_axi_awready,
  output logic [ADDR_W-1:0] out_axi_awaddr,
  output logic [PROT_W-1:0] out_axi_awprot,
  output logic              out_axi_wvalid,
  input  logic              out_axi_wready,
  output logic [DATA_W-1:0] out_axi_wdata,
  output logic [STRB_W-1:0] out_axi_wstrb,
  input  logic              out_axi_bvalid,
  output logic              out_axi_bready,
  output logic              out_axi_arvalid,
  input  logic              out_axi_arready,
  output logic [ADDR_W-1:0] out_axi_araddr,
  output logic [PROT_W-1:0] out_axi_arprot,
  input  logic              out_axi_rvalid,
  output logic              out_axi_rready,
  input  logic [DATA_W-1:0] out_axi_rdata
`ifdef PICODEVICE_AXI_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_mem_grants,
  output logic [31:0]       stat_dmm_grants
`endif
);

  state_e state_q, state_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   grant, win, arb_en, txn_done;
  logic [1:0] req;

  logic in_wa, in_wr, in_ra, in_rd;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [DATA_W-1:0] r_data;
  logic win_is_wr;

  // Granted-master views of the master-side inputs
  logic              g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic [ADDR_W-1:0] g_awaddr, g_araddr;
  logic [PROT_W-1:0] g_awprot, g_arprot;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;

  assign req[MST_MEM] = mem_axi_awvalid | mem_axi_arvalid;
  assign req[MST_DMM] = dmm_axi_awvalid | dmm_axi_arvalid;

  picodevice_arb_rr2 #(
    .ROUND_ROBIN    (ROUND_ROBIN),
    .DMM_FIRST_RESET(DMM_FIRST_RESET)
  ) u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req_i   (req),
    .arb_en_i(arb_en),
    .done_i  (txn_done),
    .win_o   (win),
    .grant_o (grant)
  );

  // A master presenting both AW and AR gets its write served first.
  assign win_is_wr = (win == MST_DMM) ? dmm_axi_awvalid : mem_axi_awvalid;

  always_comb begin
    if (grant == MST_DMM) begin
      g_awvalid = dmm_axi_awvalid;
      g_awaddr  = dmm_axi_awaddr;
      g_awprot  = dmm_axi_awprot;
      g_wvalid  = dmm_axi_wvalid;
      g_wdata   = dmm_axi_wdata;
      g_wstrb   = dmm_axi_wstrb;
      g_bready  = dmm_axi_bready;
      g_arvalid = dmm_axi_arvalid;
      g_araddr  = dmm_axi_araddr;
      g_arprot  = dmm_axi_arprot;
      g_rready  = dmm_axi_rready;
    end else begin
      g_awvalid = mem_axi_awvalid;
      g_awaddr  = mem_axi_awaddr;
      g_awprot  = mem_axi_awprot;
      g_wvalid  = mem_axi_wvalid;
      g_wdata   = mem_axi_wdata;
      g_wstrb   = mem_axi_wstrb;
      g_bready  = mem_axi_bready;
      g_arvalid = mem_axi_arvalid;
      g_araddr  = mem_axi_araddr;
      g_arprot  = mem_axi_arprot;
      g_rready  = mem_axi_rready;
    end
  end

  assign in_wa = (state_q == WR_ADDR);
  assign in_wr = (state_q == WR_RESP);
  assign in_ra = (state_q == RD_ADDR);
  assign in_rd = (state_q == RD_DATA);

  // Merged master side; a completed AW or W is masked until the write ends.
  assign out_axi_awvalid = in_wa & g_awvalid & ~aw_done_q;
  assign out_axi_awaddr  = in_wa ? g_awaddr : '0;
  assign out_axi_awprot  = in_wa ? g_awprot : '0;
  assign out_axi_wvalid  = in_wa & g_wvalid & ~w_done_q;
  assign out_axi_wdata   = in_wa ? g_wdata : '0;
  assign out_axi_wstrb   = in_wa ? g_wstrb : '0;
  assign out_axi_bready  = in_wr & g_bready;
  assign out_axi_arvalid = in_ra & g_arvalid;
  assign out_axi_araddr  = in_ra ? g_araddr : '0;
  assign out_axi_arprot  = in_ra ? g_arprot : '0;
  assign out_axi_rready  = in_rd & g_rready;

  assign aw_rdy = in_wa & out_axi_awready & ~aw_done_q;
  assign w_rdy  = in_wa & out_axi_wready & ~w_done_q;
  assign b_vld  = in_wr & out_axi_bvalid;
  assign ar_rdy = in_ra & out_axi_arready;
  assign r_vld  = in_rd & out_axi_rvalid;
  assign r_data = in_rd ? out_axi_rdata : '0;

  assign aw_hs = out_axi_awvalid & out_axi_awready;
  assign w_hs  = out_axi_wvalid & out_axi_wready;
  assign b_hs  = b_vld & out_axi_bready;
  assign ar_hs = out_axi_arvalid & out_axi_arready;
  assign r_hs  = r_vld & out_axi_rready;

  // Per-master fan-out; the non-granted master sees all zeros.
  assign mem_axi_awready = (grant == MST_MEM) & aw_rdy;
  assign mem_axi_wready  = (grant == MST_MEM) & w_rdy;
  assign mem_axi_bvalid  = (grant == MST_MEM) & b_vld;
  assign mem_axi_arready = (grant == MST_MEM) & ar_rdy;
  assign mem_axi_rvalid  = (grant == MST_MEM) & r_vld;
  assign mem_axi_rdata   = (grant == MST_MEM) ? r_data : '0;
  assign dmm_axi_awready = (grant == MST_DMM) & aw_rdy;
  assign dmm_axi_wready  = (grant == MST_DMM) & w_rdy;
  assign dmm_axi_bvalid  = (grant == MST_DMM) & b_vld;
  assign dmm_axi_arready = (grant == MST_DMM) & ar_rdy;
  assign dmm_axi_rvalid  = (grant == MST_DMM) & r_vld;
  assign dmm_axi_rdata   = (grant == MST_DMM) ? r_data : '0;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arb_en    = 1'b0;
    txn_done  = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (|req) begin
          state_d = win_is_wr ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          txn_done = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          state_d  = IDLE;
          txn_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef PICODEVICE_AXI_ARBITER_STATS_EN
  logic [31:0] stat_mem_q, stat_dmm_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_mem_q <= '0;
      stat_dmm_q <= '0;
    end else if (txn_done) begin
      if (grant == MST_MEM) stat_mem_q <= stat_mem_q + 32'd1;
      else                  stat_dmm_q <= stat_dmm_q + 32'd1;
    end
  end

  assign stat_mem_grants = stat_mem_q;
  assign stat_dmm_grants = stat_dmm_q;
`endif

endmodule

// File: tb/tb_picodevice_axi_arbiter.sv
// Directed bench for picodevice_axi_arbiter: a round-robin instance (u_dut)
// and a fixed-priority instance (u_fix) share all stimulus.
module tb_picodevice_axi_arbiter;
  import picodevice_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // bench-driven inputs
  logic mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready;
  logic [31:0] mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr;
  logic [2:0] mem_axi_awprot, mem_axi_arprot;
  logic [3:0] mem_axi_wstrb;
  logic dmm_axi_awvalid, dmm_axi_wvalid, dmm_axi_bready, dmm_axi_arvalid, dmm_axi_rready;
  logic [31:0] dmm_axi_awaddr, dmm_axi_wdata, dmm_axi_araddr;
  logic [2:0] dmm_axi_awprot, dmm_axi_arprot;
  logic [3:0] dmm_axi_wstrb;
  logic out_axi_awready, out_axi_wready, out_axi_bvalid, out_axi_arready, out_axi_rvalid;
  logic [31:0] out_axi_rdata;

  // round-robin DUT outputs
  logic mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid;
  logic [31:0] mem_axi_rdata;
  logic dmm_axi_awready, dmm_axi_wready, dmm_axi_bvalid, dmm_axi_arready, dmm_axi_rvalid;
  logic [31:0] dmm_axi_rdata;
  logic out_axi_awvalid, out_axi_wvalid, out_axi_bready, out_axi_arvalid, out_axi_rready;
  logic [31:0] out_axi_awaddr, out_axi_wdata, out_axi_araddr;
  logic [2:0] out_axi_awprot, out_axi_arprot;
  logic [3:0] out_axi_wstrb;

  // fixed-priority DUT outputs
  logic f_mem_axi_awready, f_mem_axi_wready, f_mem_axi_bvalid, f_mem_axi_arready, f_mem_axi_rvalid;
  logic [31:0] f_mem_axi_rdata;
  logic f_dmm_axi_awready, f_dmm_axi_wready, f_dmm_axi_bvalid, f_dmm_axi_arready, f_dmm_axi_rvalid;
  logic [31:0] f_dmm_axi_rdata;
  logic f_out_axi_awvalid, f_out_axi_wvalid, f_out_axi_bready, f_out_axi_arvalid, f_out_axi_rready;
  logic [31:0] f_out_axi_awaddr, f_out_axi_wdata, f_out_axi_araddr;
  logic [2:0] f_out_axi_awprot, f_out_axi_arprot;
  logic [3:0] f_out_axi_wstrb;

`ifdef PICODEVICE_AXI_ARBITER_STATS_EN
  logic [31:0] stat_mem_grants, stat_dmm_grants, f_stat_mem_grants, f_stat_dmm_grants;
`endif

  picodevice_axi_arbiter #(.ROUND_ROBIN(1), .DMM_FIRST_RESET(0)) u_dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready), .mem_axi_rdata(mem_axi_rdata),
    .dmm_axi_awvalid(dmm_axi_awvalid), .dmm_axi_awready(dmm_axi_awready),
    .dmm_axi_awaddr(dmm_axi_awaddr), .dmm_axi_awprot(dmm_axi_awprot),
    .dmm_axi_wvalid(dmm_axi_wvalid), .dmm_axi_wready(dmm_axi_wready),
    .dmm_axi_wdata(dmm_axi_wdata), .dmm_axi_wstrb(dmm_axi_wstrb),
    .dmm_axi_bvalid(dmm_axi_bvalid), .dmm_axi_bready(dmm_axi_bready),
    .dmm_axi_arvalid(dmm_axi_arvalid), .dmm_axi_arready(dmm_axi_arready),
    .dmm_axi_araddr(dmm_axi_araddr), .dmm_axi_arprot(dmm_axi_arprot),
    .dmm_axi_rvalid(dmm_axi_rvalid), .dmm_axi_rready(dmm_axi_rready), .dmm_axi_rdata(dmm_axi_rdata),
    .out_axi_awvalid(out_axi_awvalid), .out_axi_awready(out_axi_awready),
    .out_axi_awaddr(out_axi_awaddr), .out_axi_awprot(out_axi_awprot),
    .out_axi_wvalid(out_axi_wvalid), .out_axi_wready(out_axi_wready),
    .out_axi_wdata(out_axi_wdata), .out_axi_wstrb(out_axi_wstrb),
    .out_axi_bvalid(out_axi_bvalid), .out_axi_bready(out_axi_bready),
    .out_axi_arvalid(out_axi_arvalid), .out_axi_arready(out_axi_arready),
    .out_axi_araddr(out_axi_araddr), .out_axi_arprot(out_axi_arprot),
    .out_axi_rvalid(out_axi_rvalid), .out_axi_rready(out_axi_rready), .out_axi_rdata(out_axi_rdata)
`ifdef PICODEVICE_AXI_ARBITER_STATS_EN
    , .stat_mem_grants(stat_mem_grants), .stat_dmm_grants(stat_dmm_grants)
`endif
  );

  picodevice_axi_arbiter #(.ROUND_ROBIN(0), .DMM_FIRST_RESET(0)) u_fix (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(f_mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(f_mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(f_mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(f_mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(f_mem_axi_rvalid), .mem_axi_rready(mem_axi_rready), .mem_axi_rdata(f_mem_axi_rdata),
    .dmm_axi_awvalid(dmm_axi_awvalid), .dmm_axi_awready(f_dmm_axi_awready),
    .dmm_axi_awaddr(dmm_axi_awaddr), .dmm_axi_awprot(dmm_axi_awprot),
    .dmm_axi_wvalid(dmm_axi_wvalid), .dmm_axi_wready(f_dmm_axi_wready),
    .dmm_axi_wdata(dmm_axi_wdata), .dmm_axi_wstrb(dmm_axi_wstrb),
    .dmm_axi_bvalid(f_dmm_axi_bvalid), .dmm_axi_bready(dmm_axi_bready),
    .dmm_axi_arvalid(dmm_axi_arvalid), .dmm_axi_arready(f_dmm_axi_arready),
    .dmm_axi_araddr(dmm_axi_araddr), .dmm_axi_arprot(dmm_axi_arprot),
    .dmm_axi_rvalid(f_dmm_axi_rvalid), .dmm_axi_rready(dmm_axi_rready), .dmm_axi_rdata(f_dmm_axi_rdata),
    .out_axi_awvalid(f_out_axi_awvalid), .out_axi_awready(out_axi_awready),
    .out_axi_awaddr(f_out_axi_awaddr), .out_axi_awprot(f_out_axi_awprot),
    .out_axi_wvalid(f_out_axi_wvalid), .out_axi_wready(out_axi_wready),
    .out_axi_wdata(f_out_axi_wdata), .out_axi_wstrb(f_out_axi_wstrb),
    .out_axi_bvalid(out_axi_bvalid), .out_axi_bready(f_out_axi_bready),
    .out_axi_arvalid(f_out_axi_arvalid), .out_axi_arready(out_axi_arready),
    .out_axi_araddr(f_out_axi_araddr), .out_axi_arprot(f_out_axi_arprot),
    .out_axi_rvalid(out_axi_rvalid), .out_axi_rready(f_out_axi_rready), .out_axi_rdata(out_axi_rdata)
`ifdef PICODEVICE_AXI_ARBITER_STATS_EN
    , .stat_mem_grants(f_stat_mem_grants), .stat_dmm_grants(f_stat_dmm_grants)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake / transfer monitors, sampled mid-cycle (a valid&ready seen
  // here completes on the following rising edge).
  int aw_hs_n = 0, w_hs_n = 0, fm_r_n = 0, fd_ar_n = 0, rm_r_n = 0, rd_r_n = 0;
  always @(negedge clk) begin
    if (out_axi_awvalid && out_axi_awready) aw_hs_n++;
    if (out_axi_wvalid && out_axi_wready) w_hs_n++;
    if (f_mem_axi_rvalid && mem_axi_rready) fm_r_n++;
    if (f_dmm_axi_arready) fd_ar_n++;
    if (mem_axi_rvalid && mem_axi_rready) rm_r_n++;
    if (dmm_axi_rvalid && dmm_axi_rready) rd_r_n++;
  end

  function automatic logic rr_any_out();
    return |{mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid, mem_axi_rdata,
             dmm_axi_awready, dmm_axi_wready, dmm_axi_bvalid, dmm_axi_arready, dmm_axi_rvalid, dmm_axi_rdata,
             out_axi_awvalid, out_axi_awaddr, out_axi_awprot, out_axi_wvalid, out_axi_wdata, out_axi_wstrb,
             out_axi_bready, out_axi_arvalid, out_axi_araddr, out_axi_arprot, out_axi_rready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready} = '0;
    {mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb} = '0;
    {dmm_axi_awvalid, dmm_axi_wvalid, dmm_axi_bready, dmm_axi_arvalid, dmm_axi_rready} = '0;
    {dmm_axi_awaddr, dmm_axi_wdata, dmm_axi_araddr, dmm_axi_awprot, dmm_axi_arprot, dmm_axi_wstrb} = '0;
    {out_axi_awready, out_axi_wready, out_axi_bvalid, out_axi_arready, out_axi_rvalid} = '0;
    out_axi_rdata = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, reset released.
  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, b3;
    // Reset state: outputs zero even with masters and slave active
    resetn = 1'b0;
    clear_inputs();
    mem_axi_arvalid = 1'b1; mem_axi_araddr = 32'hFFFF_0000;
    out_axi_rvalid = 1'b1; out_axi_rdata = 32'h1234_5678; out_axi_arready = 1'b1;
    #12;
    expect_eq("rst_outputs", rr_any_out(), 1'b0);
    expect_eq("rst_fix_arvalid", f_out_axi_arvalid, 1'b0);

    // Single mem read
    do_reset();
    out_axi_arready = 1'b1;
    mem_axi_arvalid = 1'b1; mem_axi_araddr = 32'h0000_0040; mem_axi_rready = 1'b1;
    smp(); expect_eq("t1_idle_arvalid", out_axi_arvalid, 1'b0);
    tick(); smp();
    expect_eq("t1_araddr", out_axi_araddr, 32'h0000_0040);
    expect_eq("t1_ar_vr", {out_axi_arvalid, mem_axi_arready, dmm_axi_arready}, 3'b110);
    tick();
    mem_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1; out_axi_rdata = 32'hDEAD_BEEF;
    smp();
    expect_eq("t1_rdata", mem_axi_rdata, 32'hDEAD_BEEF);
    expect_eq("t1_r_vr", {mem_axi_rvalid, out_axi_rready, out_axi_arvalid}, 3'b110);
    expect_eq("t1_dmm_quiet", {dmm_axi_awready, dmm_axi_wready, dmm_axi_bvalid, dmm_axi_arready,
                               dmm_axi_rvalid, |dmm_axi_rdata}, 6'b0);
    tick(); out_axi_rvalid = 1'b0;
    smp(); expect_eq("t1_done", mem_axi_rvalid, 1'b0);

    // Simultaneous mem write and dmm read under round robin
    do_reset();
    out_axi_awready = 1'b1; out_axi_wready = 1'b1; out_axi_arready = 1'b1;
    mem_axi_awvalid = 1'b1; mem_axi_awaddr = 32'h100; mem_axi_awprot = 3'b010;
    mem_axi_wvalid = 1'b1; mem_axi_wdata = 32'h1234_5678; mem_axi_wstrb = 4'hF; mem_axi_bready = 1'b1;
    dmm_axi_arvalid = 1'b1; dmm_axi_araddr = 32'h200; dmm_axi_rready = 1'b1;
    smp(); expect_eq("t2_idle_awvalid", out_axi_awvalid, 1'b0);
    tick(); smp();
    expect_eq("t2_aw", {out_axi_awvalid, out_axi_awaddr, out_axi_awprot}, {1'b1, 32'h100, 3'b010});
    expect_eq("t2_w", {out_axi_wvalid, out_axi_wdata, out_axi_wstrb}, {1'b1, 32'h1234_5678, 4'hF});
    expect_eq("t2_no_rd", {out_axi_arvalid, dmm_axi_arready}, 2'b00);
    tick();
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0; out_axi_bvalid = 1'b1;
    smp(); expect_eq("t2_b", {mem_axi_bvalid, out_axi_bready, out_axi_awvalid, dmm_axi_bvalid}, 4'b1100);
    tick(); out_axi_bvalid = 1'b0;
    smp(); expect_eq("t2_gap", out_axi_arvalid, 1'b0);
    tick(); smp();
    expect_eq("t2_dmm_ar", {out_axi_arvalid, out_axi_araddr, dmm_axi_arready, mem_axi_arready},
              {1'b1, 32'h200, 2'b10});
    tick();
    dmm_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1; out_axi_rdata = 32'hCAFE_F00D;
    smp(); expect_eq("t2_dmm_r", {dmm_axi_rvalid, dmm_axi_rdata, mem_axi_rvalid}, {1'b1, 32'hCAFE_F00D, 1'b0});
    tick(); out_axi_rvalid = 1'b0;
    // mem read alone hands priority to dmm
    mem_axi_arvalid = 1'b1; mem_axi_araddr = 32'h300; mem_axi_rready = 1'b1;
    tick(); tick();
    mem_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1;
    tick(); out_axi_rvalid = 1'b0;
    mem_axi_arvalid = 1'b1; mem_axi_araddr = 32'h400;
    dmm_axi_arvalid = 1'b1; dmm_axi_araddr = 32'h500;
    tick(); smp();
    expect_eq("t2_pair_dmm_first", {out_axi_araddr, dmm_axi_arready, mem_axi_arready}, {32'h500, 2'b10});
    tick(); dmm_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1;
    tick(); out_axi_rvalid = 1'b0;
    tick(); smp();
    expect_eq("t2_pair_mem_next", {out_axi_araddr, mem_axi_arready, dmm_axi_arready}, {32'h400, 2'b10});
    tick(); mem_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1;
    tick(); out_axi_rvalid = 1'b0;

    // W ahead of AW
    do_reset();
    b0 = aw_hs_n; b1 = w_hs_n;
    out_axi_wready = 1'b1;
    mem_axi_wvalid = 1'b1; mem_axi_wdata = 32'hA5A5_A5A5; mem_axi_wstrb = 4'h3; mem_axi_bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); expect_eq("t3_w_early", {mem_axi_wready, out_axi_wvalid}, 2'b00);
      tick();
    end
    mem_axi_awvalid = 1'b1; mem_axi_awaddr = 32'h80;
    tick(); smp();
    expect_eq("t3_both_valid", {out_axi_wvalid, out_axi_awvalid, mem_axi_wready, mem_axi_awready}, 4'b1110);
    tick(); out_axi_awready = 1'b1;
    smp();
    expect_eq("t3_w_done", {out_axi_wvalid, mem_axi_wready, out_axi_awvalid, mem_axi_awready}, 4'b0011);
    tick();
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0; out_axi_bvalid = 1'b1;
    smp(); expect_eq("t3_b", {mem_axi_bvalid, out_axi_bready}, 2'b11);
    tick(); out_axi_bvalid = 1'b0; out_axi_awready = 1'b0; out_axi_wready = 1'b0;
    smp();
    expect_eq("t3_aw_hs", aw_hs_n - b0, 1);
    expect_eq("t3_w_hs", w_hs_n - b1, 1);

    // Continuous reads from both masters: fixed vs round robin
    do_reset();
    b0 = fm_r_n; b1 = fd_ar_n; b2 = rm_r_n; b3 = rd_r_n;
    out_axi_arready = 1'b1; out_axi_rvalid = 1'b1; out_axi_rdata = 32'h11;
    mem_axi_arvalid = 1'b1; mem_axi_rready = 1'b1; dmm_axi_arvalid = 1'b1; dmm_axi_rready = 1'b1;
    repeat (12) @(posedge clk);
    #1 clear_inputs();
    smp();
    expect_eq("t4_fix_mem_txn", fm_r_n - b0, 4);
    expect_eq("t4_fix_dmm_arready", fd_ar_n - b1, 0);
    expect_eq("t4_rr_mem_txn", rm_r_n - b2, 2);
    expect_eq("t4_rr_dmm_txn", rd_r_n - b3, 2);

    // Stalled write response
    do_reset();
    out_axi_awready = 1'b1; out_axi_wready = 1'b1; out_axi_arready = 1'b1;
    mem_axi_awvalid = 1'b1; mem_axi_awaddr = 32'h600; mem_axi_wvalid = 1'b1; mem_axi_wdata = 32'h77;
    mem_axi_wstrb = 4'hF;
    tick(); tick();
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0; out_axi_bvalid = 1'b1;
    dmm_axi_arvalid = 1'b1; dmm_axi_araddr = 32'h700; dmm_axi_rready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      expect_eq("t5_hold", {mem_axi_bvalid, out_axi_bready, dmm_axi_arready, out_axi_arvalid}, 4'b1000);
      tick();
    end
    mem_axi_bready = 1'b1;
    smp(); expect_eq("t5_bready", out_axi_bready, 1'b1);
    tick(); out_axi_bvalid = 1'b0;
    smp(); expect_eq("t5_idle", out_axi_arvalid, 1'b0);
    tick(); smp();
    expect_eq("t5_dmm_ar", {out_axi_araddr, dmm_axi_arready}, {32'h700, 1'b1});
    tick(); dmm_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1;
    tick(); out_axi_rvalid = 1'b0;

    // Reset while in RD_DATA, then a fresh dmm read
    do_reset();
    out_axi_arready = 1'b1;
    dmm_axi_arvalid = 1'b1; dmm_axi_araddr = 32'h800;
    tick(); tick();
    dmm_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1; out_axi_rdata = 32'h5555_AAAA;
    smp(); expect_eq("t6_rd_data", {dmm_axi_rvalid, dmm_axi_rdata, out_axi_rready}, {1'b1, 32'h5555_AAAA, 1'b0});
    tick(); smp(); expect_eq("t6_rd_held", dmm_axi_rvalid, 1'b1);
    #1 resetn = 1'b0;
    #1 expect_eq("t6_async_rst", rr_any_out(), 1'b0);
    @(posedge clk); #3 resetn = 1'b1;
    tick();
    out_axi_rvalid = 1'b0;
    dmm_axi_arvalid = 1'b1; dmm_axi_araddr = 32'h900; dmm_axi_rready = 1'b1;
    smp(); expect_eq("t6_idle", out_axi_arvalid, 1'b0);
    tick(); smp();
    expect_eq("t6_new_ar", {out_axi_araddr, dmm_axi_arready}, {32'h900, 1'b1});
    tick(); dmm_axi_arvalid = 1'b0; out_axi_rvalid = 1'b1; out_axi_rdata = 32'h1357_9BDF;
    smp(); expect_eq("t6_new_r", {dmm_axi_rvalid, dmm_axi_rdata, out_axi_rready}, {1'b1, 32'h1357_9BDF, 1'b1});
    tick(); out_axi_rvalid = 1'b0;
    smp(); expect_eq("t6_end", dmm_axi_rvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
